// File: rtl/reg_writeback_if.sv
// Port bundle of the writeback stage: execute-side request, memory read channel,
// decode read ports and retire outputs. dbg_state mirrors the stage FSM.
interface reg_writeback_if #(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5
);
    // Handshakes: a transfer happens on a rising CLK edge where valid && ready are both
    // high; the initiator holds its payload stable while valid is high and ready is low.
    // mem_resp_valid has no ready: the stage consumes exactly one response while waiting.
    logic              in_valid;
    logic              in_ready;
    logic [REG_AW-1:0] in_rd;
    logic [2:0]        in_funct3;
    logic              in_mem_acc;
    logic [XLEN-1:0]   in_result;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [XLEN-1:0]   mem_addr;
    logic              mem_resp_valid;
    logic [XLEN-1:0]   mem_resp_data;

    logic [REG_AW-1:0] rs1_addr;
    logic [XLEN-1:0]   rs1_data;
    logic [REG_AW-1:0] rs2_addr;
    logic [XLEN-1:0]   rs2_data;

    logic              wb_valid;
    logic [REG_AW-1:0] wb_rd;
    logic [XLEN-1:0]   wb_data;
    logic              load_err;
    logic [1:0]        dbg_state;

    modport slave (
        input  in_valid, in_rd, in_funct3, in_mem_acc, in_result,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        input  rs1_addr, rs2_addr,
        output in_ready, mem_req_valid, mem_addr,
        output rs1_data, rs2_data,
        output wb_valid, wb_rd, wb_data, load_err, dbg_state
    );

    modport master (
        output in_valid, in_rd, in_funct3, in_mem_acc, in_result,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        output rs1_addr, rs2_addr,
        input  in_ready, mem_req_valid, mem_addr,
        input  rs1_data, rs2_data,
        input  wb_valid, wb_rd, wb_data, load_err, dbg_state
    );
endinterface

// File: rtl/reg_writeback.sv
// Writeback stage: owns the 32x64 register file, retires ALU results and completes loads.
// Optional macro WB_BYPASS_EN forwards the value being written this cycle to the read ports.
module reg_writeback #(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5
) (
    input  logic            CLK,
    input  logic            RST,
    reg_writeback_if.slave  bus
);
    localparam int NREG = 1 << REG_AW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [2:0]        off_q, off_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic              wb_valid_q, wb_valid_d;
    logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;
    logic              load_err_q, load_err_d;
    logic [XLEN-1:0]   regs_q [NREG];
    logic [XLEN-1:0]   regs_d [NREG];

    logic              we;
    logic [REG_AW-1:0] wa;
    logic [XLEN-1:0]   wd;
    logic              misaligned;
    logic [XLEN-1:0]   shifted;
    logic [XLEN-1:0]   load_val;

    // Width/offset legality of an incoming load; funct3=111 has no load encoding.
    always_comb begin
        misaligned = 1'b0;
        unique case (bus.in_funct3)
            3'b001, 3'b101: misaligned = bus.in_result[0];
            3'b010, 3'b110: misaligned = |bus.in_result[1:0];
            3'b011:         misaligned = |bus.in_result[2:0];
            3'b111:         misaligned = 1'b1;
            default:        misaligned = 1'b0;
        endcase
    end

    always_comb begin
        shifted  = bus.mem_resp_data >> {off_q, 3'b000};
        load_val = shifted;
        unique case (funct3_q)
            3'b000:  load_val = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
            3'b001:  load_val = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            3'b010:  load_val = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
            3'b100:  load_val = {{(XLEN-8){1'b0}},         shifted[7:0]};
            3'b101:  load_val = {{(XLEN-16){1'b0}},        shifted[15:0]};
            3'b110:  load_val = {{(XLEN-32){1'b0}},        shifted[31:0]};
            default: load_val = shifted;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        rd_d       = rd_q;
        funct3_d   = funct3_q;
        off_d      = off_q;
        addr_d     = addr_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        load_err_d = 1'b0;
        we         = 1'b0;
        wa         = bus.in_rd;
        wd         = bus.in_result;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (!bus.in_mem_acc) begin
                        we         = 1'b1;
                        wb_valid_d = 1'b1;
                        wb_rd_d    = bus.in_rd;
                        wb_data_d  = (bus.in_rd == '0) ? '0 : bus.in_result;
                    end else if (misaligned) begin
                        load_err_d = 1'b1;
                    end else begin
                        rd_d     = bus.in_rd;
                        funct3_d = bus.in_funct3;
                        off_d    = bus.in_result[2:0];
                        addr_d   = {bus.in_result[XLEN-1:3], 3'b000};
                        state_d  = REQ;
                    end
                end
            end
            REQ: begin
                if (bus.mem_req_ready) state_d = WAIT;
            end
            WAIT: begin
                if (bus.mem_resp_valid) begin
                    we         = 1'b1;
                    wa         = rd_q;
                    wd         = load_val;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_data_d  = (rd_q == '0) ? '0 : load_val;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        regs_d = regs_q;
        if (we && wa != '0) regs_d[wa] = wd;
    end

    // x0 reads as zero regardless of array contents.
    always_comb begin
        bus.rs1_data = (bus.rs1_addr == '0) ? '0 : regs_q[bus.rs1_addr];
        bus.rs2_data = (bus.rs2_addr == '0) ? '0 : regs_q[bus.rs2_addr];
`ifdef WB_BYPASS_EN
        if (we && wa != '0 && wa == bus.rs1_addr) bus.rs1_data = wd;
        if (we && wa != '0 && wa == bus.rs2_addr) bus.rs2_data = wd;
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            rd_q       <= '0;
            funct3_q   <= '0;
            off_q      <= '0;
            addr_q     <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            load_err_q <= 1'b0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            funct3_q   <= funct3_d;
            off_q      <= off_d;
            addr_q     <= addr_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            load_err_q <= load_err_d;
            regs_q     <= regs_d;
        end
    end

    assign bus.in_ready      = (state_q == IDLE);
    assign bus.mem_req_valid = (state_q == REQ);
    assign bus.mem_addr      = addr_q;
    assign bus.wb_valid      = wb_valid_q;
    assign bus.wb_rd         = wb_rd_q;
    assign bus.wb_data       = wb_data_q;
    assign bus.load_err      = load_err_q;
    assign bus.dbg_state     = state_q;
endmodule
